// File: rtl/usrt_pkg.sv
// usrt_pkg: definitions shared by the USRT blocks (statusreg, usrt_tx, usrt_rx).
//   tx_state_t  - transmitter frame state
//   PARITY_BIT  - status bit holding the parity enable
//   BAUD_LSB/MSB- status field holding the baud code N (bit period 2<<N)
//   DATA_W      - data bits per frame
package usrt_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam int PARITY_BIT = 0;
  localparam int BAUD_LSB   = 1;
  localparam int BAUD_MSB   = 3;
  localparam int DATA_W     = 8;

  // Last count of a half bit period: H-1 = (1<<N)-1, so 0 for N=0 and 127 for N=7.
  function automatic logic [7:0] half_last(input logic [2:0] baud);
    logic [7:0] half;
    half = 8'd1 << baud;
    return half - 8'd1;
  endfunction

endpackage

// File: rtl/usrt_baudgen.sv
// usrt_baudgen: bit-period timing for the USRT transmitter.
//   pclk, reset_n - system clock and asynchronous active-low reset
//   enable        - high while a frame is in flight; low holds the count at zero
//   baud          - latched baud code N, bit period T = 2<<N cycles
//   half_tick     - last cycle of the first (low) half of a bit slot
//   bit_tick      - last cycle of a bit slot
module usrt_baudgen
  import usrt_pkg::*;
(
  input  logic       pclk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [2:0] baud,
  output logic       half_tick,
  output logic       bit_tick
);

  logic [7:0] half_cnt;
  logic       phase;
  logic       term;

  assign term = (half_cnt == half_last(baud));

  // Held at zero while disabled, so every frame starts counting from a clean slot.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      half_cnt <= 8'd0;
      phase    <= 1'b0;
    end else if (!enable) begin
      half_cnt <= 8'd0;
      phase    <= 1'b0;
    end else if (term) begin
      half_cnt <= 8'd0;
      phase    <= ~phase;
    end else begin
      half_cnt <= half_cnt + 8'd1;
    end
  end

  assign half_tick = enable & term & ~phase;
  assign bit_tick  = enable & term & phase;

endmodule

// File: rtl/usrt_tx.sv
// usrt_tx: synchronous serial transmitter for the USRT.
// Frame: start(0), 8 data bits LSB first, optional even parity, stop(1).
//   i_Pclk, i_Reset_n - system clock and asynchronous active-low reset
//   i_Status          - config word: bit0 parity enable, bits[3:1] baud code N
//   i_Data, i_Valid   - byte to send, accepted when i_Valid and o_Ready
//   o_Ready           - idle, can accept a byte
//   o_Sclk            - serial clock, low for the first half of each slot
//   o_Txd             - serial data, changes on the o_Sclk falling edge
//   o_Done            - one-cycle pulse when a frame completes
//
// state  | meaning
// IDLE   | line high, waiting for a byte
// START  | driving the start bit (0)
// DATA   | driving data bit bit_idx
// PARITY | driving even parity of the byte
// STOP   | driving the stop bit (1)
module usrt_tx
  import usrt_pkg::*;
(
  input  logic              i_Pclk,
  input  logic              i_Reset_n,
  input  logic [7:0]        i_Status,
  input  logic [DATA_W-1:0] i_Data,
  input  logic              i_Valid,
  output logic              o_Ready,
  output logic              o_Sclk,
  output logic              o_Txd,
  output logic              o_Done
);

  tx_state_t         state;
  logic [DATA_W-1:0] shreg;
  logic              parity_acc;
  logic [3:0]        bit_idx;
  logic [2:0]        baud_q;
  logic              par_en_q;
  logic              half_tick;
  logic              bit_tick;
  logic              accept;
  logic              unused_status_hi;

  assign unused_status_hi = ^i_Status[7:BAUD_MSB+1];
  assign accept           = i_Valid & o_Ready;

  usrt_baudgen u_baudgen (
    .pclk      (i_Pclk),
    .reset_n   (i_Reset_n),
    .enable    (state != IDLE),
    .baud      (baud_q),
    .half_tick (half_tick),
    .bit_tick  (bit_tick)
  );

  always_ff @(posedge i_Pclk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state      <= IDLE;
      shreg      <= '0;
      parity_acc <= 1'b0;
      bit_idx    <= 4'd0;
      baud_q     <= 3'd0;
      par_en_q   <= 1'b0;
      o_Ready    <= 1'b1;
      o_Sclk     <= 1'b1;
      o_Txd      <= 1'b1;
      o_Done     <= 1'b0;
    end else begin
      o_Done <= 1'b0;
      // Rising serial clock mid-slot; the slot boundary below pulls it low again.
      if (half_tick) o_Sclk <= 1'b1;
      case (state)
        IDLE: begin
          if (accept) begin
            shreg      <= i_Data;
            baud_q     <= i_Status[BAUD_MSB:BAUD_LSB];
            par_en_q   <= i_Status[PARITY_BIT];
            parity_acc <= 1'b0;
            bit_idx    <= 4'd0;
            o_Ready    <= 1'b0;
            o_Txd      <= 1'b0;
            o_Sclk     <= 1'b0;
            state      <= START;
          end
        end
        START: begin
          if (bit_tick) begin
            o_Txd  <= shreg[0];
            o_Sclk <= 1'b0;
            state  <= DATA;
          end
        end
        DATA: begin
          if (bit_tick) begin
            parity_acc <= parity_acc ^ shreg[0];
            shreg      <= shreg >> 1;
            o_Sclk     <= 1'b0;
            if (bit_idx == 4'(DATA_W - 1)) begin
              // Parity must include the bit that is finishing now.
              if (par_en_q) begin
                o_Txd <= parity_acc ^ shreg[0];
                state <= PARITY;
              end else begin
                o_Txd <= 1'b1;
                state <= STOP;
              end
            end else begin
              o_Txd   <= shreg[1];
              bit_idx <= bit_idx + 4'd1;
            end
          end
        end
        PARITY: begin
          if (bit_tick) begin
            o_Txd  <= 1'b1;
            o_Sclk <= 1'b0;
            state  <= STOP;
          end
        end
        STOP: begin
          if (bit_tick) begin
            o_Ready <= 1'b1;
            o_Done  <= 1'b1;
            o_Sclk  <= 1'b1;
            o_Txd   <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usrt_tx.sv
module tb_usrt_tx;

  logic       i_Pclk;
  logic       i_Reset_n;
  logic [7:0] i_Status;
  logic [7:0] i_Data;
  logic       i_Valid;
  logic       o_Ready;
  logic       o_Sclk;
  logic       o_Txd;
  logic       o_Done;

  int errors = 0;
  int checks = 0;

  usrt_tx dut (
    .i_Pclk    (i_Pclk),
    .i_Reset_n (i_Reset_n),
    .i_Status  (i_Status),
    .i_Data    (i_Data),
    .i_Valid   (i_Valid),
    .o_Ready   (o_Ready),
    .o_Sclk    (o_Sclk),
    .o_Txd     (o_Txd),
    .o_Done    (o_Done)
  );

  initial i_Pclk = 1'b0;
  always #5 i_Pclk = ~i_Pclk;

  // Compared vector is {o_Txd, o_Sclk, o_Ready, o_Done}.
  task automatic chk(input string tag, input int idx, input logic [3:0] exp);
    logic [3:0] got;
    got = {o_Txd, o_Sclk, o_Ready, o_Done};
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s[%0d]: got txd/sclk/rdy/done=%b expected %b", tag, idx, got, exp);
    end
  endtask

  // Present a byte at the current negedge; returns at the negedge of cycle k+1.
  task automatic start(input string tag, input logic [7:0] status, input logic [7:0] data,
                       input logic keep_valid);
    chk(tag, 0, 4'b1110);
    i_Status = status;
    i_Data   = data;
    i_Valid  = 1'b1;
    @(posedge i_Pclk);
    @(negedge i_Pclk);
    i_Valid = keep_valid;
  endtask

  // Called at the negedge of cycle k+1. Checks every cycle through the o_Done cycle
  // (k+done_off). Slot bits: bits[j] is the level of slot j. At cycle poke_cyc the
  // inputs are overwritten to exercise busy/mid-frame behaviour.
  task automatic check_frame(input string tag, input logic [10:0] bits, input int t_bit,
                             input int done_off, input int poke_cyc,
                             input logic [7:0] poke_status, input logic [7:0] poke_data,
                             input logic poke_valid);
    int slot;
    int pos;
    for (int c = 1; c <= done_off; c++) begin
      if (c > 1) @(negedge i_Pclk);
      if (c == poke_cyc) begin
        i_Status = poke_status;
        i_Data   = poke_data;
        i_Valid  = poke_valid;
      end
      if (c < done_off) begin
        slot = (c - 1) / t_bit;
        pos  = (c - 1) % t_bit;
        chk(tag, c, {bits[slot], (pos >= t_bit / 2), 2'b00});
      end else begin
        chk(tag, c, 4'b1111);
      end
    end
  endtask

  initial begin
    i_Reset_n = 1'b0;
    i_Status  = 8'h00;
    i_Data    = 8'h00;
    i_Valid   = 1'b0;
    repeat (3) @(negedge i_Pclk);
    chk("reset", 0, 4'b1110);
    i_Reset_n = 1'b1;
    @(negedge i_Pclk);
    chk("post_reset", 0, 4'b1110);

    // A5 with parity, T=2: slots 0,1,0,1,0,0,1,0,1,0,1; done at k+23.
    start("par_acc", 8'h01, 8'hA5, 1'b0);
    check_frame("par_a5", 11'b10101001010, 2, 23, 0, 8'h00, 8'h00, 1'b0);
    @(negedge i_Pclk);
    chk("par_idle", 0, 4'b1110);

    // 80 without parity, T=2: slots 0,0,0,0,0,0,0,0,1,1; done at k+21.
    start("nopar_acc", 8'h00, 8'h80, 1'b0);
    check_frame("nopar_80", 11'b01100000000, 2, 21, 0, 8'h00, 8'h00, 1'b0);
    @(negedge i_Pclk);
    chk("nopar_idle", 0, 4'b1110);

    // 01 with parity, N=6 T=128: parity bit 1, ready low 1408 cycles.
    start("slow_acc", 8'h0D, 8'h01, 1'b0);
    check_frame("slow_01", 11'b11000000010, 128, 1409, 0, 8'h00, 8'h00, 1'b0);
    @(negedge i_Pclk);
    chk("slow_idle", 0, 4'b1110);

    // Busy: valid held, FF offered mid-frame and status changed to N=3 no parity.
    // First frame (5A, T=2, parity 0) must be unaffected; FF is taken at o_Done.
    start("busy_acc", 8'h01, 8'h5A, 1'b1);
    check_frame("busy_5a", 11'b10010110100, 2, 23, 5, 8'h06, 8'hFF, 1'b1);
    @(negedge i_Pclk);
    // FF, N=3 T=16, no parity; status cleared mid-frame must not change T.
    check_frame("busy_ff", 11'b01111111110, 16, 161, 3, 8'h00, 8'h96, 1'b1);
    @(negedge i_Pclk);
    // Back-to-back: 96, T=2, no parity, one idle cycle before the start bit.
    check_frame("b2b_96", 11'b01100101100, 2, 21, 2, 8'h00, 8'h96, 1'b0);
    @(negedge i_Pclk);
    chk("b2b_idle", 0, 4'b1110);

    // Reset mid-frame while Txd and Sclk are both low.
    start("rst_acc", 8'h01, 8'h3C, 1'b0);
    @(negedge i_Pclk);
    @(negedge i_Pclk);
    chk("rst_pre", 3, 4'b0000);
    #2 i_Reset_n = 1'b0;
    #1 chk("rst_async", 0, 4'b1110);
    @(negedge i_Pclk);
    @(negedge i_Pclk);
    i_Reset_n = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge i_Pclk);
      chk("rst_no_done", c, 4'b1110);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
